// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch/decode encodings, vectors and PC helper
package mips_pkg;

  typedef enum logic [2:0] {
    PCSRC_SEQ    = 3'b000,
    PCSRC_JUMP   = 3'b001,
    PCSRC_JR     = 3'b010,
    PCSRC_EXC    = 3'b011,
    PCSRC_BRANCH = 3'b100,
    PCSRC_IRQ    = 3'b101
  } pcsrc_e;

  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] IRQ_VECTOR   = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR   = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  // Bit 31 is the kernel-mode bit; sequential fetch wraps within its half.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// rtl/next_pc_mux.sv - combinational next-PC target selection and redirect flag
module next_pc_mux
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  pcsrc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_reg,
  input  logic [3:0]  jump_region,
  input  logic [25:0] jump_index,
  output logic [31:0] pc4,
  output logic [31:0] next_pc,
  output logic        redirect
);

  assign pc4 = pc_plus4(pc);

  always_comb begin
    next_pc  = pc4;
    redirect = 1'b0;
    case (pcsrc)
      PCSRC_JUMP: begin
        next_pc  = {jump_region, jump_index, 2'b00};
        redirect = 1'b1;
      end
      PCSRC_JR: begin
        next_pc  = jump_reg;
        redirect = 1'b1;
      end
      PCSRC_EXC: begin
        next_pc  = EXC_VECTOR;
        redirect = 1'b1;
      end
      PCSRC_BRANCH: begin
        if (branch_taken) begin
          next_pc  = branch_target;
          redirect = 1'b1;
        end
      end
      PCSRC_IRQ: begin
        next_pc  = IRQ_VECTOR;
        redirect = 1'b1;
      end
      default: begin
        next_pc  = pc4;
        redirect = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, IF/ID pipeline register and interrupt pending flag
module fetch_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSrc,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpReg,
  input  logic        Stall,
  input  logic        Irq,
  input  logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid,
  output logic        Interrupt
);

  logic [31:0] pc4;
  logic [31:0] next_pc;
  logic        redirect;
  logic        pending;

  next_pc_mux u_next_pc_mux (
    .pc           (PC),
    .pcsrc        (PCSrc),
    .branch_taken (BranchTaken),
    .branch_target(BranchTarget),
    .jump_reg     (JumpReg),
    .jump_region  (IF_ID_PC4[31:28]),
    .jump_index   (IF_ID_Instr[25:0]),
    .pc4          (pc4),
    .next_pc      (next_pc),
    .redirect     (redirect)
  );

  // Only user-mode, valid, non-stalled instructions in ID may take an interrupt.
  assign Interrupt = pending & IF_ID_Valid & ~IF_ID_PC4[31] & ~Stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      PC          <= RESET_VECTOR;
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_PC4   <= 32'h0000_0000;
      IF_ID_Valid <= 1'b0;
      pending     <= 1'b0;
    end else begin
      // A new request wins over the clear of one taken on the same cycle.
      if (Irq) begin
        pending <= 1'b1;
      end else if (Interrupt) begin
        pending <= 1'b0;
      end

      if (!Stall) begin
        PC <= next_pc;
        if (redirect) begin
          IF_ID_Instr <= NOP_INSTR;
          IF_ID_PC4   <= 32'h0000_0000;
          IF_ID_Valid <= 1'b0;
        end else begin
          IF_ID_Instr <= Instruction;
          IF_ID_PC4   <= pc4;
          IF_ID_Valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [2:0]  PCSrc;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] JumpReg;
  logic        Stall;
  logic        Irq;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_Valid;
  logic        Interrupt;

  typedef struct {
    int          step;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        intr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .PCSrc       (PCSrc),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .JumpReg     (JumpReg),
    .Stall       (Stall),
    .Irq         (Irq),
    .Instruction (Instruction),
    .PC          (PC),
    .IF_ID_Instr (IF_ID_Instr),
    .IF_ID_PC4   (IF_ID_PC4),
    .IF_ID_Valid (IF_ID_Valid),
    .Interrupt   (Interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int step, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", step, name, act, expv);
    end
  endtask

  // Monitor: each entry describes what the DUT shows while that step's inputs are applied.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("PC", e.step, PC, e.pc);
      cmp("IF_ID_Instr", e.step, IF_ID_Instr, e.instr);
      cmp("IF_ID_PC4", e.step, IF_ID_PC4, e.pc4);
      cmp("IF_ID_Valid", e.step, {31'd0, IF_ID_Valid}, {31'd0, e.valid});
      cmp("Interrupt", e.step, {31'd0, Interrupt}, {31'd0, e.intr});
    end
  end

  task automatic step(
    input logic        rst,
    input logic [2:0]  src,
    input logic        bt,
    input logic [31:0] btgt,
    input logic [31:0] jreg,
    input logic        stl,
    input logic        irq,
    input logic [31:0] instr,
    input logic [31:0] e_pc,
    input logic [31:0] e_instr,
    input logic [31:0] e_pc4,
    input logic        e_valid,
    input logic        e_int
  );
    exp_t e;
    reset        = rst;
    PCSrc        = src;
    BranchTaken  = bt;
    BranchTarget = btgt;
    JumpReg      = jreg;
    Stall        = stl;
    Irq          = irq;
    Instruction  = instr;
    e.step  = step_no;
    e.pc    = e_pc;
    e.instr = e_instr;
    e.pc4   = e_pc4;
    e.valid = e_valid;
    e.intr  = e_int;
    exp_q.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; PCSrc = 3'b000; BranchTaken = 1'b0; BranchTarget = '0;
    JumpReg = '0; Stall = 1'b0; Irq = 1'b0; Instruction = '0;
    @(posedge clk);
    #1;
    //   rst  src    bt    btgt           jreg           stl   irq   instr          e_pc           e_instr        e_pc4          v     int
    step(1'b1, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h8000_0000, 32'h0,         32'h0,         1'b0, 1'b0);
    // sequential fetch from the reset vector
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h1111_1111, 32'h8000_0000, 32'h0,         32'h0,         1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h2222_2222, 32'h8000_0004, 32'h1111_1111, 32'h8000_0004, 1'b1, 1'b0);
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h3333_3333, 32'h8000_0008, 32'h2222_2222, 32'h8000_0008, 1'b1, 1'b0);
    // three stalled cycles with a jump request pending
    step(1'b0, 3'b001, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h4444_4444, 32'h8000_000C, 32'h3333_3333, 32'h8000_000C, 1'b1, 1'b0);
    step(1'b0, 3'b001, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h4444_4444, 32'h8000_000C, 32'h3333_3333, 32'h8000_000C, 1'b1, 1'b0);
    step(1'b0, 3'b001, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h4444_4444, 32'h8000_000C, 32'h3333_3333, 32'h8000_000C, 1'b1, 1'b0);
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h4444_4444, 32'h8000_000C, 32'h3333_3333, 32'h8000_000C, 1'b1, 1'b0);
    // jr into user space, then taken and not-taken branches
    step(1'b0, 3'b010, 1'b0, 32'h0,         32'h0040_0010, 1'b0, 1'b0, 32'h5555_5555, 32'h8000_0010, 32'h4444_4444, 32'h8000_0010, 1'b1, 1'b0);
    step(1'b0, 3'b100, 1'b1, 32'h0040_0040, 32'h0,         1'b0, 1'b0, 32'h6666_6666, 32'h0040_0010, 32'h0,         32'h0,         1'b0, 1'b0);
    step(1'b0, 3'b100, 1'b0, 32'h0000_1234, 32'h0,         1'b0, 1'b0, 32'h7777_7777, 32'h0040_0040, 32'h0,         32'h0,         1'b0, 1'b0);
    // j target formed from IF/ID, then exception vector
    step(1'b0, 3'b010, 1'b0, 32'h0,         32'h0040_0FFC, 1'b0, 1'b0, 32'h8888_8888, 32'h0040_0044, 32'h7777_7777, 32'h0040_0044, 1'b1, 1'b0);
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0810_0010, 32'h0040_0FFC, 32'h0,         32'h0,         1'b0, 1'b0);
    step(1'b0, 3'b001, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h9999_9999, 32'h0040_1000, 32'h0810_0010, 32'h0040_1000, 1'b1, 1'b0);
    step(1'b0, 3'b011, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h9999_9999, 32'h0040_0040, 32'h0,         32'h0,         1'b0, 1'b0);
    // user-half wrap keeps bit 31 clear
    step(1'b0, 3'b010, 1'b0, 32'h0,         32'h7FFF_FFFC, 1'b0, 1'b0, 32'h9999_9999, 32'h8000_0008, 32'h0,         32'h0,         1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'hAAAA_AAAA, 32'h7FFF_FFFC, 32'h0,         32'h0,         1'b0, 1'b0);
    // Irq in kernel mode stays pending until a user instruction reaches ID
    step(1'b0, 3'b010, 1'b0, 32'h0,         32'h8000_00FC, 1'b0, 1'b0, 32'hAAAA_AAAA, 32'h0000_0000, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1, 1'b0);
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'hBBBB_BBBB, 32'h8000_00FC, 32'h0,         32'h0,         1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'hCCCC_CCCC, 32'h8000_0100, 32'hBBBB_BBBB, 32'h8000_0100, 1'b1, 1'b0);
    step(1'b0, 3'b010, 1'b0, 32'h0,         32'h0040_0000, 1'b0, 1'b0, 32'hDDDD_DDDD, 32'h8000_0104, 32'hCCCC_CCCC, 32'h8000_0104, 1'b1, 1'b0);
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'hEEEE_EEEE, 32'h0040_0000, 32'h0,         32'h0,         1'b0, 1'b0);
    step(1'b0, 3'b101, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'hEEEE_EEEE, 32'h0040_0004, 32'hEEEE_EEEE, 32'h0040_0004, 1'b1, 1'b1);
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h1234_5678, 32'h8000_0004, 32'h0,         32'h0,         1'b0, 1'b0);
    // pending is cleared: a later user instruction does not interrupt
    step(1'b0, 3'b010, 1'b0, 32'h0,         32'h0040_0100, 1'b0, 1'b0, 32'h1234_5678, 32'h8000_0008, 32'h1234_5678, 32'h8000_0008, 1'b1, 1'b0);
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0F0F_0F0F, 32'h0040_0100, 32'h0,         32'h0,         1'b0, 1'b0);
    // Irq during stall sets pending, Stall masks Interrupt
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0000_0001, 32'h0040_0104, 32'h0F0F_0F0F, 32'h0040_0104, 1'b1, 1'b0);
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_0001, 32'h0040_0104, 32'h0F0F_0F0F, 32'h0040_0104, 1'b1, 1'b0);
    step(1'b0, 3'b101, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0001, 32'h0040_0104, 32'h0F0F_0F0F, 32'h0040_0104, 1'b1, 1'b1);
    // reset overrides a redirect, then overrides nothing while stalled
    step(1'b1, 3'b010, 1'b0, 32'h0,         32'h0040_0200, 1'b0, 1'b0, 32'h0000_0002, 32'h8000_0004, 32'h0,         32'h0,         1'b0, 1'b0);
    step(1'b1, 3'b001, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_0003, 32'h8000_0000, 32'h0,         32'h0,         1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_0004, 32'h8000_0000, 32'h0,         32'h0,         1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0005, 32'h8000_0000, 32'h0,         32'h0,         1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0006, 32'h8000_0004, 32'h0000_0005, 32'h8000_0004, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk input 1: single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset input 1: synchronous, active-high reset.
REQ-003 SHALL have port PCSrc input 3: next-PC select from ID-stage decoder (encodings per REQ-014).
REQ-004 SHALL have port BranchTaken input 1: ID-stage branch comparison result, qualifies PCSrc=100.
REQ-005 SHALL have port BranchTarget input 32: ID-stage computed branch target.
REQ-006 SHALL have port JumpReg input 32: forwarded rs value for jr/jalr.
REQ-007 SHALL have port Stall input 1: hazard-unit hold request.
REQ-008 SHALL have port Irq input 1: level external interrupt request.
REQ-009 SHALL have port Instruction input 32: instruction-memory read data for address PC (combinational read).
REQ-010 SHALL have port PC output 32: instruction-memory address.
REQ-011 SHALL have ports IF_ID_Instr output 32, IF_ID_PC4 output 32, IF_ID_Valid output 1: IF/ID pipeline register.
REQ-012 SHALL have port Interrupt output 1: interrupt-take indication to decoder.

Function
REQ-013 PC+4 SHALL preserve kernel bit: PC4 = {PC[31], PC[30:0]+4}, 31-bit wrap, bit 31 never carried into.
REQ-014 PCSrc decode SHALL be: 000 PC4; 001 {IF_ID_PC4[31:28], IF_ID_Instr[25:0], 2'b00}; 010 JumpReg (all 32 bits, bit 31 included); 011 0x80000008; 100 BranchTarget if BranchTaken else PC4; 101 0x80000004.
REQ-015 Redirect SHALL be PCSrc in {001,010,011,101} or (PCSrc=100 and BranchTaken=1).
REQ-016 Irq SHALL set a pending flag on any cycle Irq=1; flag clears only on the cycle Interrupt=1 is consumed (not stalled).
REQ-017 Interrupt SHALL equal pending & IF_ID_Valid & ~IF_ID_PC4[31] & ~Stall (no interrupts in kernel mode or on bubbles).
REQ-018 Priority per cycle SHALL be: reset > Stall > redirect > sequential.
REQ-019 Stall=1: PC, IF/ID register hold; PCSrc ignored; pending flag may still set.
REQ-020 Redirect (no Stall): PC <= target next edge; IF/ID <= bubble (Instr 0x00000000, PC4 0, Valid 0); one-cycle penalty.
REQ-021 Sequential: PC <= PC4; IF_ID_Instr <= Instruction; IF_ID_PC4 <= PC4; IF_ID_Valid <= 1.
REQ-022 Latency: instruction at PC appears on IF_ID_Instr exactly one cycle after PC presented, absent stall/redirect.
REQ-023 Irq asserted while in kernel mode SHALL remain pending until a user-mode valid instruction reaches ID.

Reset
REQ-024 On reset PC SHALL be 0x80000000, IF_ID_Instr 0, IF_ID_PC4 0, IF_ID_Valid 0, pending 0; Interrupt 0.
REQ-025 Reset mid-stall or mid-redirect SHALL override both on the same edge.
REQ-026 First fetch after reset release SHALL be from 0x80000000.

Structure
REQ-027 PCSrc encodings, reset vector 0x80000000, interrupt vector 0x80000004, exception vector 0x80000008, NOP constant SHALL live in shared package mips_pkg, also used by decoder.
REQ-028 Combinational target selection SHALL be one sub-module next_pc_mux; PC, IF/ID and pending registers stay in fetch_stage.

Verification
REQ-029 Reset, no stall, PCSrc=000 -> PC 0x80000000, 0x80000004, 0x80000008; IF_ID_PC4 0x80000004 one cycle after first fetch, Valid=1.
REQ-030 PC=0x00400010, PCSrc=100, BranchTaken=1, BranchTarget=0x00400040 -> PC 0x00400040 next edge, IF_ID_Valid=0, Instr 0 for one cycle.
REQ-031 Stall=1 three cycles with PCSrc=001 -> PC, IF_ID_* unchanged throughout; resumes at PC4 after release.
REQ-032 Irq pulse one cycle while IF_ID_PC4=0x80000100 -> Interrupt=0; after jr to 0x00400000 and valid fetch, Interrupt=1 once, PC 0x80000004, pending cleared.
REQ-033 IF_ID_PC4=0x00401000, IF_ID_Instr[25:0]=0x0100010, PCSrc=001 -> PC 0x00400040; PCSrc=011 -> PC 0x80000008.
REQ-034 PC=0x7FFFFFFC sequential -> PC 0x00000000 (bit 31 preserved 0); reset asserted during redirect -> PC 0x80000000.
